uart_deframer: RTL and testbench
================================

Name: uart_deframer

Overview:
- UART receive-side counterpart of the transmit framer.
- Samples the serial line with a 16x oversampling tick, finds the start bit and reassembles the data bits. Checks parity and stop bits, then presents a parallel byte with a one-cycle valid strobe and error flags.
- Uses the same configuration encoding as the transmit path, so one config register drives both ends.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
- rx_in  input  1  asynchronous serial line; idles high.
- data_length  input  1  0 = 7 data bits, 1 = 8 data bits.
- parity_type  input  2  01 = odd, 10 = even, 00/11 = no parity bit.
- stop_bits  input  1  0 = 1 stop bit, 1 = 2 stop bits.
- data_out  output  8  received data, LSB first on the line; bit 7 forced to 0 in 7-bit mode.
- data_valid  output  1  one-clk pulse when a frame completes.
- parity_error  output  1  valid with data_valid; received parity mismatches the check.
- frame_error  output  1  valid with data_valid; any stop-bit sample was 0.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. With rst=1 at a clk edge:
  - state goes to IDLE and the synchronizer flops go to 1;
  - data_out = 0, data_valid = 0, parity_error = 0, frame_error = 0, busy = 0.
- Reset mid-frame aborts the frame; no data_valid is produced for it.
- Synchronizer: rx_in passes through 2 flops (rx_s) before any use.
- Timing rules:
  - All state and counter updates occur only on clk edges where baud_tick = 1, except the data_valid clear.
  - The tick counter is log2(OVERSAMPLE) bits wide.
- Configuration: data_length, parity_type and stop_bits are latched when START is entered. Changes mid-frame have no effect until the next frame.
- States and transitions:
  - IDLE: when rx_s = 0 on a tick, go to START, clear the tick counter, set busy.
  - START: count to OVERSAMPLE/2-1 (mid-bit), then re-sample rx_s.
    - rx_s = 1 means a glitch or false start: return to IDLE with no outputs.
    - rx_s = 0: go to DATA, clear the counter and bit index.
  - DATA: sample rx_s every OVERSAMPLE ticks (mid-bit) into shift position bit_idx, LSB first.
    - After 7 or 8 bits (latched data_length): go to PARITY if parity is enabled (01/10), else to STOP1.
  - PARITY: sample the parity bit at mid-bit. The check covers the XOR of the received data bits (7 or 8) and the parity bit.
    - Odd: total number of ones must be odd.
    - Even: total number of ones must be even.
    - A mismatch sets the internal perr flag.
  - STOP1: sample at mid-bit; a 0 sets the internal ferr flag.
    - With 1 stop bit, finish (see Completion).
    - With 2 stop bits, go to STOP2.
  - STOP2: sample at mid-bit; a 0 sets ferr, then finish.
  - WAIT_HIGH: entered after a frame with ferr = 1. Stays until rx_s = 1 on a tick, then goes to IDLE. This prevents re-triggering on a held-low (break) line.
- Completion (on the final stop-bit mid-sample tick):
  - data_out is loaded with the assembled data; in 7-bit mode bit 7 = 0.
  - parity_error = perr, frame_error = ferr, data_valid = 1 for exactly one clk.
  - Next state is IDLE (or WAIT_HIGH if ferr = 1) and busy drops.
  - Back-to-back frames: IDLE is entered at mid-stop, so a start edge half a bit later is accepted.
- Output holding:
  - data_out, parity_error and frame_error hold their values until the next completion.
  - data_valid is 0 on every other cycle.
- Latency: data_valid rises on the clk edge of the tick that samples the mid-point of the final stop bit. That is (1 + N_data + N_parity + N_stop - 0.5) bit periods after the start edge, plus 2 clks of synchronizer delay.
- No rx_in back-pressure: a second frame overwrites data_out at its completion.

Decomposition:
- Shared package uart_pkg:
  - parity encodings PAR_NONE = 00, PAR_ODD = 01, PAR_EVEN = 10;
  - data_length and stop_bits encodings;
  - receiver state enum (IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH);
  - default OVERSAMPLE.
- One sub-module, uart_rx_sync: the 2-flop synchronizer with a synchronous reset to 1.

Test Plan:
- 8 data bits, no parity, 1 stop, send 0xA5 -> one data_valid pulse, data_out = 0xA5, parity_error = 0, frame_error = 0, busy low afterwards.
- 7 data bits, odd parity, 2 stops, send 0x35 (four ones) with parity bit 1 -> data_out = 0x35, no errors. Repeat with parity bit 0 -> parity_error = 1, data_out = 0x35.
- 8 data bits, even parity, 1 stop, send 0x0F with parity 0 -> no error. Then send 0x3C back-to-back with the start edge half a bit after mid-stop -> second data_valid with data_out = 0x3C.
- Stop bit forced to 0, line held low for 3 bit periods -> frame_error = 1 with data_valid. No further data_valid until the line returns high and a new start bit is sent.
- rx_in low glitch for 4 ticks -> no data_valid, busy returns to 0 after mid-start. Then a valid frame 0x5A is received correctly.
- rst asserted during DATA for 1 clk -> all outputs 0, no data_valid for the aborted frame. Next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART encodings and receiver state set; one config register drives both TX framer and RX deframer.
// No logic here: constants and types only.
// No flow control involved.
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic DL_7   = 1'b0;
    localparam logic DL_8   = 1'b1;
    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
// Latency: 2 clk.
// Backpressure: none.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s
);

    logic rx_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_deframer.sv
// UART receiver: oversampled start detect, mid-bit sampling, parity/stop checks, one-clk valid strobe.
// Latency: (1 + data + parity + stop - 0.5) bit periods after the start edge, plus 2 clk sync.
// Backpressure: none; a later frame overwrites data_out at its completion.
module uart_deframer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx_in,
    input  logic       data_length,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic            rx_s;
    rx_state_t       state;
    logic [CW-1:0]   tick_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            cfg_len;
    logic [1:0]      cfg_par;
    logic            cfg_stop;
    logic            perr;
    logic            ferr;

    logic            bit_done;
    logic            par_en;
    logic [2:0]      last_idx;
    logic            ones_odd;
    logic            ferr_next;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

    assign bit_done  = (tick_cnt == BIT_CNT);
    assign par_en    = (cfg_par == PAR_ODD) || (cfg_par == PAR_EVEN);
    assign last_idx  = (cfg_len == DL_8) ? 3'd7 : 3'd6;
    // shreg[7] is cleared at frame start, so in 7-bit mode it adds nothing to the XOR
    assign ones_odd  = (^shreg) ^ rx_s;
    assign ferr_next = ferr | ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            cfg_len      <= DL_8;
            cfg_par      <= PAR_NONE;
            cfg_stop     <= STOP_1;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                            cfg_len  <= data_length;
                            cfg_par  <= parity_type;
                            cfg_stop <= stop_bits;
                            shreg    <= '0;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                        end
                    end
                    START: begin
                        if (tick_cnt == MID_CNT) begin
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            tick_cnt       <= '0;
                            shreg[bit_idx] <= rx_s;
                            if (bit_idx == last_idx) begin
                                state <= par_en ? PARITY : STOP1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                    PARITY: begin
                        if (bit_done) begin
                            tick_cnt <= '0;
                            perr     <= (cfg_par == PAR_ODD) ? ~ones_odd : ones_odd;
                            state    <= STOP1;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                    STOP1, STOP2: begin
                        if (bit_done) begin
                            tick_cnt <= '0;
                            if (state == STOP1 && cfg_stop == STOP_2) begin
                                ferr  <= ferr_next;
                                state <= STOP2;
                            end else begin
                                // Returning to IDLE at mid-stop lets a back-to-back start edge be caught
                                data_out     <= (cfg_len == DL_8) ? shreg : {1'b0, shreg[6:0]};
                                parity_error <= perr;
                                frame_error  <= ferr_next;
                                data_valid   <= 1'b1;
                                busy         <= 1'b0;
                                state        <= ferr_next ? WAIT_HIGH : IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_ONE;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_deframer.sv
// Self-checking bench for uart_deframer: frame-level reference model with expected-frame queue and timing window.
module tb_uart_deframer;

    localparam int OS     = 16;
    localparam int TPC    = 2;
    localparam int BITCLK = OS * TPC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       data_length = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    int     dv_seen = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        longint     lo;
        longint     hi;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] hold_d = 8'h00;
    logic       hold_pe = 1'b0;
    logic       hold_fe = 1'b0;

    uart_deframer #(.OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx_in        (rx_in),
        .data_length  (data_length),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        baud_tick = ~baud_tick;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Per-cycle comparison against the frame-level model
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                hold_d  = 8'h00;
                hold_pe = 1'b0;
                hold_fe = 1'b0;
                chk("valid_in_reset", 32'(data_valid), 32'(0));
                chk("busy_in_reset", 32'(busy), 32'(0));
            end else if (data_valid) begin
                dv_seen++;
                chk("valid_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("valid_timing", 32'(cyc >= e.lo && cyc <= e.hi), 32'(1));
                    hold_d  = e.d;
                    hold_pe = e.pe;
                    hold_fe = e.fe;
                end
            end else if (exp_q.size() != 0) begin
                chk("valid_deadline", 32'(cyc <= exp_q[0].hi), 32'(1));
                if (cyc > exp_q[0].hi) void'(exp_q.pop_front());
            end
            chk("data_out", 32'(data_out), 32'(hold_d));
            chk("parity_error", 32'(parity_error), 32'(hold_pe));
            chk("frame_error", 32'(frame_error), 32'(hold_fe));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one complete frame; queues its expected outcome at the start edge
    task automatic send_frame(input logic dl, input logic [1:0] pt, input logic sb,
                              input logic [7:0] d, input logic flip_par,
                              input logic stop0, input logic stop1v,
                              input int tail_low, input bit scramble);
        logic       bits[$];
        logic [7:0] de;
        logic       pen;
        logic       pb;
        int         nd;
        int         k;
        exp_t       e;
        nd  = dl ? 8 : 7;
        de  = d;
        if (!dl) de[7] = 1'b0;
        pen = (pt == 2'b01) || (pt == 2'b10);
        pb  = (pt == 2'b01) ? ($countones(de) % 2 == 0) : ($countones(de) % 2 == 1);
        pb  = pb ^ flip_par;
        for (int i = 0; i < nd; i++) bits.push_back(de[i]);
        if (pen) bits.push_back(pb);
        bits.push_back(stop0);
        if (sb) bits.push_back(stop1v);
        k = bits.size();
        data_length = dl;
        parity_type = pt;
        stop_bits   = sb;
        e.d  = de;
        e.pe = pen & flip_par;
        e.fe = !stop0 || (sb && !stop1v);
        e.lo = cyc + longint'(BITCLK * k + BITCLK / 2 + 2);
        e.hi = cyc + longint'(BITCLK * k + BITCLK / 2 + 6);
        exp_q.push_back(e);
        rx_in = 1'b0;
        idle(BITCLK / 2);
        if (scramble) begin
            data_length = 1'($urandom_range(0, 1));
            parity_type = 2'($urandom_range(0, 3));
            stop_bits   = 1'($urandom_range(0, 1));
        end
        idle(BITCLK / 2);
        foreach (bits[i]) begin
            rx_in = bits[i];
            idle(BITCLK);
        end
        if (tail_low > 0) begin
            rx_in = 1'b0;
            idle(tail_low);
        end
        rx_in = 1'b1;
    endtask

    initial begin
        int   dv0;
        logic fe_last;
        idle(4);
        chk("reset_data_out", 32'(data_out), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        idle(40);

        send_frame(1'b1, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("a5_data", 32'(data_out), 32'(8'hA5));
        chk("a5_perr", 32'(parity_error), 32'(0));
        chk("a5_ferr", 32'(frame_error), 32'(0));
        chk("a5_busy_after", 32'(busy), 32'(0));
        chk("a5_count", 32'(dv_seen), 32'(1));
        idle(20);

        send_frame(1'b0, 2'b01, 1'b1, 8'h35, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("odd_ok_data", 32'(data_out), 32'(8'h35));
        chk("odd_ok_perr", 32'(parity_error), 32'(0));
        idle(20);
        send_frame(1'b0, 2'b01, 1'b1, 8'h35, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        chk("odd_bad_data", 32'(data_out), 32'(8'h35));
        chk("odd_bad_perr", 32'(parity_error), 32'(1));
        idle(20);

        send_frame(1'b1, 2'b10, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("even_0f_data", 32'(data_out), 32'(8'h0F));
        chk("even_0f_perr", 32'(parity_error), 32'(0));
        send_frame(1'b1, 2'b10, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("b2b_3c_data", 32'(data_out), 32'(8'h3C));
        chk("b2b_count", 32'(dv_seen), 32'(5));
        idle(20);

        dv0 = dv_seen;
        send_frame(1'b1, 2'b00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 3 * BITCLK, 1'b0);
        chk("break_ferr", 32'(frame_error), 32'(1));
        chk("break_data", 32'(data_out), 32'(8'h81));
        chk("break_single_valid", 32'(dv_seen - dv0), 32'(1));
        idle(2 * BITCLK);
        send_frame(1'b1, 2'b00, 1'b0, 8'h66, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("after_break_data", 32'(data_out), 32'(8'h66));
        chk("after_break_ferr", 32'(frame_error), 32'(0));
        idle(20);

        dv0 = dv_seen;
        rx_in = 1'b0;
        idle(6);
        chk("glitch_busy_high", 32'(busy), 32'(1));
        idle(2);
        rx_in = 1'b1;
        idle(32);
        chk("glitch_busy_low", 32'(busy), 32'(0));
        chk("glitch_no_valid", 32'(dv_seen - dv0), 32'(0));
        send_frame(1'b1, 2'b00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("glitch_next_data", 32'(data_out), 32'(8'h5A));
        idle(20);

        dv0 = dv_seen;
        data_length = 1'b1;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        rx_in = 1'b0;
        idle(BITCLK);
        rx_in = 1'b1;
        idle(BITCLK + BITCLK / 2);
        chk("pre_abort_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("abort_data_out", 32'(data_out), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_valid", 32'(data_valid), 32'(0));
        idle(3 * BITCLK);
        chk("abort_no_valid", 32'(dv_seen - dv0), 32'(0));
        send_frame(1'b1, 2'b00, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("abort_next_data", 32'(data_out), 32'(8'hC3));
        idle(20);

        for (int n = 0; n < 40; n++) begin
            logic       dl;
            logic [1:0] pt;
            logic       sb;
            logic       s0;
            logic       s1;
            dl = 1'($urandom_range(0, 1));
            pt = 2'($urandom_range(0, 3));
            sb = 1'($urandom_range(0, 1));
            s0 = ($urandom_range(0, 7) != 0);
            s1 = ($urandom_range(0, 7) != 0);
            send_frame(dl, pt, sb, 8'($urandom), ($urandom_range(0, 3) == 0), s0, s1, 0, 1'b1);
            fe_last = !s0 || (sb && !s1);
            idle(int'($urandom_range(0, 40)) + (fe_last ? 8 : 0));
        end

        idle(3 * BITCLK);
        chk("no_pending_frames", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
